// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM edge-fetch sequencer: default widths, buffer
// layout offsets and the sequencer state encoding.
package sram_pkg;

    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 8;

    localparam int HDR_N_OFS     = 0;
    localparam int HDR_E_OFS     = 1;
    localparam int EDGE_BASE_OFS = 2;
    localparam int EDGE_BYTES    = 3;

    typedef logic [3:0] fetchState_t;

    localparam fetchState_t ST_IDLE    = 4'd0;
    localparam fetchState_t ST_RD_N    = 4'd1;
    localparam fetchState_t ST_RD_E    = 4'd2;
    localparam fetchState_t ST_CHECK   = 4'd3;
    localparam fetchState_t ST_RD_SRC  = 4'd4;
    localparam fetchState_t ST_RD_DST  = 4'd5;
    localparam fetchState_t ST_RD_WT   = 4'd6;
    localparam fetchState_t ST_PRESENT = 4'd7;
    localparam fetchState_t ST_DONE    = 4'd8;

    // Number of buffer bytes occupied by the header plus an edge list of e edges.
    function automatic int edgeListBytes(input logic [7:0] e);
        return EDGE_BASE_OFS + EDGE_BYTES * int'(e);
    endfunction

endpackage

// File: rtl/sram_edge_fetch_ctr.sv
// Edge-index and pass counters for the edge replay, with terminal-count flags
// for the last edge of a pass and the final pass.
module sram_edge_fetch_ctr (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] edgeTotal,
    input  logic [7:0] lastPass,
    output logic [7:0] passIdx,
    output logic       edgeTc,
    output logic       passTc
);

    logic [7:0] edgeIdx;

    assign edgeTc = (edgeIdx == edgeTotal - 8'd1);
    assign passTc = (passIdx >= lastPass);

    // Edge index wraps at the end of each pass; the pass count saturates at the final pass.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            edgeIdx <= 8'd0;
            passIdx <= 8'd0;
        end else if (clear) begin
            edgeIdx <= 8'd0;
            passIdx <= 8'd0;
        end else if (advance) begin
            if (edgeTc) begin
                edgeIdx <= 8'd0;
                if (!passTc) begin
                    passIdx <= passIdx + 8'd1;
                end
            end else begin
                edgeIdx <= edgeIdx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sram_edge_fetch.sv
// Graph-load sequencer: reads N, E and the edge triples from the input buffer SRAM
// and replays the edge list N-1 times. Optional macro: SRAM_EDGE_PREFETCH_EN.
module sram_edge_fetch
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 1024,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  edge_valid,
    input  logic                  edge_ready,
    output logic [DATA_WIDTH-1:0] edge_src,
    output logic [DATA_WIDTH-1:0] edge_dst,
    output logic [DATA_WIDTH-1:0] edge_weight,
    output logic                  edge_last,
    output logic [7:0]            pass_idx,
    output logic [7:0]            node_count,
    output logic [7:0]            edge_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] HDR_ADDR  = ADDR_WIDTH'(BASE_ADDR + HDR_N_OFS);
    localparam logic [ADDR_WIDTH-1:0] EDGE_ADDR = ADDR_WIDTH'(BASE_ADDR + EDGE_BASE_OFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    fetchState_t state;
    logic        handshake;
    logic        presEdgeTc;
    logic        passTc;
    logic [7:0]  lastPass;

    assign handshake = edge_valid & edge_ready;
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign lastPass  = node_count - 8'd2;

    sram_edge_fetch_ctr presCtr (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == ST_CHECK),
        .advance   ((state == ST_PRESENT) && handshake),
        .edgeTotal (edge_count),
        .lastPass  (lastPass),
        .passIdx   (pass_idx),
        .edgeTc    (presEdgeTc),
        .passTc    (passTc)
    );

`ifdef SRAM_EDGE_PREFETCH_EN
    logic [DATA_WIDTH-1:0] pfSrc;
    logic [DATA_WIDTH-1:0] pfDst;
    logic [DATA_WIDTH-1:0] pfWt;
    logic [1:0]            pfCount;
    logic                  pfLast;
    logic                  fetchDone;
    logic                  pfActive;
    logic                  wtRead;
    logic                  fetchEdgeTc;
    logic                  fetchPassTc;
    logic [7:0]            fetchPassIdx;
    logic [ADDR_WIDTH-1:0] wtNextAddr;

    // The fetch side runs ahead of the presented edge, so it keeps its own counters.
    assign pfActive   = !fetchDone && (pfCount != 2'd3);
    assign wtRead     = (state == ST_RD_WT) ||
                        ((state == ST_PRESENT) && pfActive && (pfCount == 2'd2));
    assign wtNextAddr = !fetchEdgeTc ? read_address + ADDR_ONE :
                        (fetchPassTc ? read_address : EDGE_ADDR);

    sram_edge_fetch_ctr fetchCtr (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == ST_CHECK),
        .advance   (wtRead),
        .edgeTotal (edge_count),
        .lastPass  (lastPass),
        .passIdx   (fetchPassIdx),
        .edgeTc    (fetchEdgeTc),
        .passTc    (fetchPassTc)
    );
`endif

    // Sequencer: header load, bounds check, then per-byte edge reads and presentation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            read_address <= HDR_ADDR;
            node_count   <= 8'd0;
            edge_count   <= 8'd0;
            edge_src     <= '0;
            edge_dst     <= '0;
            edge_weight  <= '0;
            edge_valid   <= 1'b0;
            edge_last    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef SRAM_EDGE_PREFETCH_EN
            pfSrc        <= '0;
            pfDst        <= '0;
            pfWt         <= '0;
            pfCount      <= 2'd0;
            pfLast       <= 1'b0;
            fetchDone    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        read_address <= HDR_ADDR;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        state        <= ST_RD_N;
                    end
                end
                ST_RD_N: begin
                    node_count   <= read_data[7:0];
                    read_address <= read_address + ADDR_ONE;
                    state        <= ST_RD_E;
                end
                ST_RD_E: begin
                    edge_count <= read_data[7:0];
                    state      <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (edgeListBytes(edge_count) > DEPTH) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if ((node_count <= 8'd1) || (edge_count == 8'd0)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        read_address <= EDGE_ADDR;
                        state        <= ST_RD_SRC;
`ifdef SRAM_EDGE_PREFETCH_EN
                        pfCount      <= 2'd0;
                        fetchDone    <= 1'b0;
`endif
                    end
                end
                ST_RD_SRC: begin
                    edge_src     <= read_data;
                    read_address <= read_address + ADDR_ONE;
                    state        <= ST_RD_DST;
                end
                ST_RD_DST: begin
                    edge_dst     <= read_data;
                    read_address <= read_address + ADDR_ONE;
                    state        <= ST_RD_WT;
                end
                ST_RD_WT: begin
                    edge_weight <= read_data;
                    edge_valid  <= 1'b1;
                    state       <= ST_PRESENT;
`ifdef SRAM_EDGE_PREFETCH_EN
                    edge_last    <= fetchEdgeTc;
                    read_address <= wtNextAddr;
                    pfCount      <= 2'd0;
                    if (fetchEdgeTc && fetchPassTc) begin
                        fetchDone <= 1'b1;
                    end
`else
                    edge_last    <= presEdgeTc;
                    read_address <= read_address + ADDR_ONE;
`endif
                end
                ST_PRESENT: begin
`ifdef SRAM_EDGE_PREFETCH_EN
                    if (pfActive) begin
                        case (pfCount)
                            2'd0:    pfSrc <= read_data;
                            2'd1:    pfDst <= read_data;
                            default: begin
                                pfWt   <= read_data;
                                pfLast <= fetchEdgeTc;
                            end
                        endcase
                        pfCount      <= pfCount + 2'd1;
                        read_address <= (pfCount == 2'd2) ? wtNextAddr : read_address + ADDR_ONE;
                        if ((pfCount == 2'd2) && fetchEdgeTc && fetchPassTc) begin
                            fetchDone <= 1'b1;
                        end
                    end
                    // Bytes already prefetched plus the one arriving now go straight to the outputs.
                    if (handshake) begin
                        pfCount <= 2'd0;
                        if (edge_last && passTc) begin
                            edge_valid <= 1'b0;
                            edge_last  <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            case (pfCount)
                                2'd3: begin
                                    edge_src    <= pfSrc;
                                    edge_dst    <= pfDst;
                                    edge_weight <= pfWt;
                                    edge_last   <= pfLast;
                                end
                                2'd2: begin
                                    edge_src    <= pfSrc;
                                    edge_dst    <= pfDst;
                                    edge_weight <= read_data;
                                    edge_last   <= fetchEdgeTc;
                                end
                                2'd1: begin
                                    edge_src   <= pfSrc;
                                    edge_dst   <= read_data;
                                    edge_valid <= 1'b0;
                                    edge_last  <= 1'b0;
                                    state      <= ST_RD_WT;
                                end
                                default: begin
                                    edge_src   <= read_data;
                                    edge_valid <= 1'b0;
                                    edge_last  <= 1'b0;
                                    state      <= ST_RD_DST;
                                end
                            endcase
                        end
                    end
`else
                    if (handshake) begin
                        edge_valid <= 1'b0;
                        edge_last  <= 1'b0;
                        if (!edge_last) begin
                            state <= ST_RD_SRC;
                        end else if (!passTc) begin
                            read_address <= EDGE_ADDR;
                            state        <= ST_RD_SRC;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
